// File: rtl/alu_muldiv_8bits_if.sv
// Request/writeback bundle between the instruction controller and the
// multiply/divide unit.
//
// Handshake: the controller raises start with op/operands/dest_address; the
// unit samples them only while idle (busy low) on a rising clock edge, then
// holds busy high until the writeback cycle completes. Operands may change
// freely after acceptance. done and write_enable pulse together for exactly
// one cycle and carry the result on write_address/write_data. A start seen
// while busy is dropped, never queued.
interface alu_muldiv_8bits_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  start;
    logic [1:0]            op;
    logic [WIDTH-1:0]      operand_a;
    logic [WIDTH-1:0]      operand_b;
    logic [ADDR_WIDTH-1:0] dest_address;
    logic                  busy;
    logic                  done;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [WIDTH-1:0]      write_data;
    logic                  div_by_zero;
    // Controller FSM state, exported for observation (0 IDLE, 1 RUN, 2 WRITE).
    logic [1:0]            dbg_state;

    modport master (
        output start, op, operand_a, operand_b, dest_address,
        input  busy, done, write_enable, write_address, write_data,
        input  div_by_zero, dbg_state
    );

    modport slave (
        input  start, op, operand_a, operand_b, dest_address,
        output busy, done, write_enable, write_address, write_data,
        output div_by_zero, dbg_state
    );
endinterface

// File: rtl/alu_muldiv_8bits.sv
// Multi-cycle unsigned multiply / divide unit.
// MUL uses shift-add into a double-width product register; DIV uses restoring
// division. One iteration per clock, WIDTH iterations, then one writeback
// cycle. All outputs come straight from flops.
module alu_muldiv_8bits #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                   clock_alu,
    input  logic                   reset,
    alu_muldiv_8bits_if.slave      bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                state_q,  state_d;
    logic [1:0]            op_q,     op_d;
    logic [WIDTH-1:0]      a_q,      a_d;
    logic [WIDTH-1:0]      b_q,      b_d;
    logic [ADDR_WIDTH-1:0] dest_q,   dest_d;
    logic [2*WIDTH-1:0]    prod_q,   prod_d;
    logic [WIDTH-1:0]      rem_q,    rem_d;
    logic [WIDTH-1:0]      quot_q,   quot_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic                  we_q,     we_d;
    logic [ADDR_WIDTH-1:0] waddr_q,  waddr_d;
    logic [WIDTH-1:0]      wdata_q,  wdata_d;
    logic                  dbz_q,    dbz_d;

    // One datapath step, shared by every RUN iteration.
    logic [WIDTH:0]        mul_sum;
    logic [2*WIDTH-1:0]    prod_step;
    logic [WIDTH:0]        rem_shift;
    logic [WIDTH:0]        rem_diff;
    logic                  b_zero;
    logic                  rem_ge;
    logic [WIDTH-1:0]      rem_step;
    logic [WIDTH-1:0]      quot_step;
    logic [WIDTH-1:0]      result;

    // Single shift-add step and single restoring-division step.
    always_comb begin
        // Add the multiplicand into the upper half when the multiplier LSB
        // is set; the carry lands in bit WIDTH and shifts right with the rest.
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        prod_step = {mul_sum, prod_q[WIDTH-1:1]};

        // quot_q starts as the dividend, so its MSB is the next dividend bit;
        // quotient bits shift in from the bottom as dividend bits leave.
        rem_shift = {rem_q, quot_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        b_zero    = (b_q == '0);
        // Since rem_q < divisor, a borrow out of rem_diff means "too small".
        // A zero divisor breaks that invariant; its results are forced anyway.
        rem_ge    = ~rem_diff[WIDTH] | b_zero;
        rem_step  = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quot_step = {quot_q[WIDTH-2:0], rem_ge};

        result = '0;
        unique case (op_q)
            2'b00: result = prod_step[WIDTH-1:0];
            2'b01: result = prod_step[2*WIDTH-1:WIDTH];
            2'b10: result = b_zero ? {WIDTH{1'b1}} : quot_step;
            2'b11: result = b_zero ? a_q : rem_step;
            default: result = '0;
        endcase
    end

    // Controller next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        dest_d  = dest_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.operand_a;
                    b_d     = bus.operand_b;
                    dest_d  = bus.dest_address;
                    prod_d  = {{WIDTH{1'b0}}, bus.operand_b};
                    rem_d   = '0;
                    quot_d  = bus.operand_a;
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                prod_d = prod_step;
                rem_d  = rem_step;
                quot_d = quot_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    wdata_d = result;
                    waddr_d = dest_q;
                    we_d    = 1'b1;
                    done_d  = 1'b1;
                    dbz_d   = op_q[1] & b_zero;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                we_d    = 1'b0;
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                we_d    = 1'b0;
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state and outputs; reset drops everything immediately.
    always_ff @(posedge clock_alu or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dest_q  <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dest_q  <= dest_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.write_enable  = we_q;
    assign bus.write_address = waddr_q;
    assign bus.write_data    = wdata_q;
    assign bus.div_by_zero   = dbz_q;
    assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_alu_muldiv_8bits.sv
// Directed bench for alu_muldiv_8bits: a driver issues requests and queues
// hand-computed results; a monitor checks every writeback against the queue.
module tb_alu_muldiv_8bits;
  localparam int W  = 8;
  localparam int AW = 3;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic          exp_dbz_q[$];
  int            exp_cyc_q[$];
  logic          prev_we;

  alu_muldiv_8bits_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  alu_muldiv_8bits #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clock_alu (clk),
    .reset     (rst),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  // Called just before a negedge-aligned posedge: drives start for one edge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [AW-1:0] dest,
                       input logic [W-1:0] exp_data, input logic exp_dbz,
                       input bit push, output int acc_cyc);
    bus.start        = 1'b1;
    bus.op           = op;
    bus.operand_a    = a;
    bus.operand_b    = b;
    bus.dest_address = dest;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (push) begin
      exp_q.push_back(exp_data);
      exp_addr_q.push_back(dest);
      exp_dbz_q.push_back(exp_dbz);
      exp_cyc_q.push_back(acc_cyc + W);
    end
    bus.start     = 1'b0;
    // Scramble operands to show they were latched.
    bus.operand_a = ~a;
    bus.operand_b = ~b;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus.write_enable) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL idle_timeout busy=%0b we=%0b", bus.busy, bus.write_enable);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [AW-1:0] dest,
                        input logic [W-1:0] exp_data, input logic exp_dbz);
    int c;
    @(negedge clk);
    issue(op, a, b, dest, exp_data, exp_dbz, 1'b1, c);
    wait_idle();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (bus.write_enable || bus.done) begin
        check("done_eq_we", bus.done, bus.write_enable);
        check("we_single_cycle", prev_we, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write addr=%0d data=0x%0h want=no_write",
                   bus.write_address, bus.write_data);
        end else begin
          check("write_data", bus.write_data, exp_q.pop_front());
          check("write_address", bus.write_address, exp_addr_q.pop_front());
          check("div_by_zero_at_write", bus.div_by_zero, exp_dbz_q.pop_front());
          check("write_latency_cycle", cyc, exp_cyc_q.pop_front());
        end
      end
      prev_we = bus.write_enable;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int c1;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    prev_we  = 1'b0;
    bus.start        = 1'b0;
    bus.op           = 2'b00;
    bus.operand_a    = '0;
    bus.operand_b    = '0;
    bus.dest_address = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_we", bus.write_enable, 0);
    check("reset_done", bus.done, 0);
    check("reset_wdata", bus.write_data, 0);
    check("reset_waddr", bus.write_address, 0);
    check("reset_dbz", bus.div_by_zero, 0);
    check("reset_state", bus.dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;

    // Multiply
    run_op(2'b00, 8'd13, 8'd11, 3'd3, 8'h8F, 1'b0);
    run_op(2'b01, 8'd13, 8'd11, 3'd3, 8'h00, 1'b0);
    run_op(2'b00, 8'd200, 8'd200, 3'd1, 8'h40, 1'b0);
    run_op(2'b01, 8'd200, 8'd200, 3'd6, 8'h9C, 1'b0);

    // Divide / remainder
    run_op(2'b10, 8'd200, 8'd7, 3'd2, 8'h1C, 1'b0);
    run_op(2'b11, 8'd200, 8'd7, 3'd2, 8'h04, 1'b0);
    run_op(2'b10, 8'd5, 8'd9, 3'd4, 8'h00, 1'b0);
    run_op(2'b11, 8'd5, 8'd9, 3'd4, 8'h05, 1'b0);
    check("dbz_clear_after_div", bus.div_by_zero, 0);

    // Divide by zero: flag sticky until the next accepted start
    run_op(2'b10, 8'h55, 8'h00, 3'd5, 8'hFF, 1'b1);
    repeat (3) @(negedge clk);
    check("dbz_held_q", bus.div_by_zero, 1);
    run_op(2'b11, 8'h55, 8'h00, 3'd5, 8'h55, 1'b1);
    check("dbz_held_r", bus.div_by_zero, 1);
    @(negedge clk);
    issue(2'b00, 8'd3, 8'd4, 3'd0, 8'h0C, 1'b0, 1'b1, c0);
    check("dbz_cleared_by_start", bus.div_by_zero, 0);
    check("busy_after_accept", bus.busy, 1);
    wait_idle();

    // Busy collision: start at E3 is ignored, start at E10 is accepted
    @(negedge clk);
    issue(2'b00, 8'd13, 8'd11, 3'd2, 8'h8F, 1'b0, 1'b1, c0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    issue(2'b01, 8'hFF, 8'hFF, 3'd7, 8'h00, 1'b0, 1'b0, c1);
    check("busy_during_collision", bus.busy, 1);
    for (int i = 0; i < 20 && cyc < c0 + 9; i++) @(negedge clk);
    check("reached_e9", cyc, c0 + 9);
    issue(2'b10, 8'd100, 8'd10, 3'd4, 8'h0A, 1'b0, 1'b1, c1);
    check("accept_at_e10", c1, c0 + 10);
    check("busy_after_e10_accept", bus.busy, 1);
    wait_idle();

    // Reset mid-run at E4: no write, outputs drop immediately
    @(negedge clk);
    issue(2'b00, 8'd13, 8'd11, 3'd3, 8'h00, 1'b0, 1'b0, c0);
    repeat (3) @(posedge clk);
    #1;
    check("busy_before_reset", bus.busy, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("reset_mid_busy", bus.busy, 0);
    check("reset_mid_we", bus.write_enable, 0);
    check("reset_mid_done", bus.done, 0);
    check("reset_mid_state", bus.dbg_state, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_write_after_reset", bus.write_enable, 0);

    run_op(2'b00, 8'd13, 8'd11, 3'd3, 8'h8F, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
